rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the CPU register file. It shares the single register-file write port between two producers: the ALU write-back path and the data-memory load-return path. Each producer has its own small queue, and ties are broken round-robin. An optional per-register scoreboard flags destinations with a load still in flight, so the decode stage can stall on RAW hazards. The block sits between the execute/memory stages and the register-file write port (`reg_write`, `write_index`, `write_data`).

---
 rtl/rf_wb_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: two producer queues, round-robin grant, optional load scoreboard.
// Define RF_WB_SCOREBOARD_EN to build the per-register busy bits; otherwise query_busy1/2 read 0.

module rf_wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [4:0]  push_index,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [4:0]  head_index,
    output logic [31:0] head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // The extra pointer bit separates a full queue from an empty one when the low bits match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [4:0]  index_mem [DEPTH];
    logic [31:0] data_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            index_mem[wr_ptr[AW-1:0]] <= push_index;
            data_mem[wr_ptr[AW-1:0]]  <= push_data;
        end
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_index = index_mem[rd_ptr[AW-1:0]];
    assign head_data  = data_mem[rd_ptr[AW-1:0]];
endmodule

module rf_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_index,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_index,
    input  logic [31:0] ld_data,
    input  logic        claim_valid,
    input  logic [4:0]  claim_index,
    input  logic [4:0]  query_index1,
    input  logic [4:0]  query_index2,
    output logic        query_busy1,
    output logic        query_busy2,
    output logic        reg_write,
    output logic [4:0]  write_index,
    output logic [31:0] write_data
);
    logic        alu_full, alu_empty, ld_full, ld_empty;
    logic [4:0]  alu_head_index, ld_head_index;
    logic [31:0] alu_head_data, ld_head_data;
    logic        grant_alu, grant_ld, grant_any;
    logic [4:0]  grant_index;
    logic [31:0] grant_data;
    logic        prefer_ld;

    assign alu_ready = !alu_full && !rst;
    assign ld_ready  = !ld_full && !rst;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_alu_q (
        .clk        (clk),
        .rst        (rst),
        .push       (alu_valid && alu_ready),
        .push_index (alu_index),
        .push_data  (alu_data),
        .pop        (grant_alu),
        .full       (alu_full),
        .empty      (alu_empty),
        .head_index (alu_head_index),
        .head_data  (alu_head_data)
    );

    rf_wb_fifo #(.DEPTH(DEPTH)) u_ld_q (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_valid && ld_ready),
        .push_index (ld_index),
        .push_data  (ld_data),
        .pop        (grant_ld),
        .full       (ld_full),
        .empty      (ld_empty),
        .head_index (ld_head_index),
        .head_data  (ld_head_data)
    );

    // Grant depends only on registered queue state, so no valid reaches the write port combinationally.
    always_comb begin
        grant_ld    = !ld_empty && (alu_empty || prefer_ld);
        grant_alu   = !alu_empty && !grant_ld;
        grant_any   = grant_ld || grant_alu;
        grant_index = grant_ld ? ld_head_index : alu_head_index;
        grant_data  = grant_ld ? ld_head_data  : alu_head_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_ld <= 1'b1;
        end else if (grant_any) begin
            prefer_ld <= grant_alu;
        end
    end

    // Writes to x0 still consume the grant slot but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write   <= 1'b0;
            write_index <= '0;
            write_data  <= '0;
        end else if (grant_any) begin
            if (grant_index != 5'd0) begin
                reg_write   <= 1'b1;
                write_index <= grant_index;
                write_data  <= grant_data;
            end else begin
                reg_write   <= 1'b0;
                write_index <= '0;
                write_data  <= '0;
            end
        end else begin
            reg_write <= 1'b0;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy;

    // The claim is assigned last so it wins over a same-edge clear of the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (grant_ld) busy[ld_head_index] <= 1'b0;
            if (claim_valid && (claim_index != 5'd0)) busy[claim_index] <= 1'b1;
        end
    end

    assign query_busy1 = busy[query_index1];
    assign query_busy2 = busy[query_index2];
`else
    logic unused_claim;
    assign unused_claim = &{1'b0, claim_valid, claim_index, query_index1, query_index2};
    assign query_busy1  = 1'b0;
    assign query_busy2  = 1'b0;
`endif
endmodule
